// File: rtl/aes_sched_pkg.sv
// rtl/aes_sched_pkg.sv - shared types and constants for the AES job scheduler
package aes_sched_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NUM_REQ     = 2;

  typedef logic [0:AES_BLOCK_W-1] aes_block_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESPOND
  } sched_state_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// rtl/aes_rr_arb2.sv - combinational two-way round-robin grant
module aes_rr_arb2
  import aes_sched_pkg::*;
(
  input  logic [0:NUM_REQ-1] req_valid,
  input  logic               last_grant,
  output logic [0:NUM_REQ-1] grant,
  output logic               grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    // On a tie the requester that was not served last wins.
    if (req_valid[0] && req_valid[1]) begin
      grant_idx = ~last_grant;
    end else if (req_valid[1]) begin
      grant_idx = 1'b1;
    end
    grant = '0;
    if (req_valid != '0) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// rtl/aes_job_scheduler.sv - shares one AES128 core between two requesters
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int CORE_LATENCY = 11,
  parameter int CNT_W        = 5
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [0:NUM_REQ-1]                      req_valid,
  output logic [0:NUM_REQ-1]                      req_ready,
  input  logic [0:NUM_REQ-1]                      req_decrypt,
  input  logic [0:NUM_REQ-1][0:AES_BLOCK_W-1]     req_message,
  input  logic [0:NUM_REQ-1][0:AES_BLOCK_W-1]     req_key,
  output logic [0:NUM_REQ-1]                      rsp_valid,
  input  logic [0:NUM_REQ-1]                      rsp_ready,
  output logic [0:AES_BLOCK_W-1]                  rsp_data,
  output logic                                    core_start,
  output logic                                    core_selCypher,
  output logic [0:AES_BLOCK_W-1]                  core_message,
  output logic [0:AES_BLOCK_W-1]                  core_key,
  input  logic [0:AES_BLOCK_W-1]                  core_result,
  output logic                                    busy
);

  sched_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic               last_grant;
  logic               owner;
  logic [0:NUM_REQ-1] grant;
  logic               grant_idx;

  aes_rr_arb2 u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The accept handshake completes in the same IDLE cycle the grant is made.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      rsp_data       <= '0;
      rsp_valid      <= '0;
      core_start     <= 1'b0;
      core_selCypher <= 1'b0;
      core_message   <= '0;
      core_key       <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != '0) begin
            core_message   <= req_message[grant_idx];
            core_key       <= req_key[grant_idx];
            core_selCypher <= req_decrypt[grant_idx];
            owner          <= grant_idx;
            core_start     <= 1'b1;
            busy           <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          core_start <= 1'b0;
          cnt        <= CNT_W'(CORE_LATENCY);
          state      <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_data         <= core_result;
            rsp_valid[owner] <= 1'b1;
            state            <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready[owner]) begin
            last_grant <= owner;
            rsp_valid  <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb/tb_aes_job_scheduler.sv - randomized self-checking bench for aes_job_scheduler
module tb_aes_job_scheduler;

  localparam int L = 11;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             reset;
  logic [0:1]       req_valid, req_ready, req_decrypt;
  logic [0:1][0:127] req_message, req_key;
  logic [0:1]       rsp_valid, rsp_ready;
  logic [0:127]     rsp_data;
  logic             core_start, core_selCypher, busy;
  logic [0:127]     core_message, core_key, core_result;

  aes_job_scheduler #(.CORE_LATENCY(L), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
    .req_message(req_message), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .core_start(core_start), .core_selCypher(core_selCypher),
    .core_message(core_message), .core_key(core_key),
    .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in core: known FIPS-197 pair, otherwise a keyed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] m, input logic [127:0] k, input logic d);
    if (!d && m == PT && k == KEY) return CT;
    if (d && m == CT && k == KEY) return PT;
    return {m[63:0], m[127:64]} ^ k ^ {128{d}};
  endfunction

  logic [L-1:0] pv;
  logic [127:0] pd [L];
  int starts = 0;
  always @(posedge clk) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv[0] <= core_start;
      pd[0] <= core_fn(core_message, core_key, core_selCypher);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (core_start) starts++;
    end
  end
  assign core_result = pv[L-1] ? pd[L-1] : {4{32'hdeadbeef}};

  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one job in flight, timed from its accept cycle.
  int           cyc = 0, t_acc = 0, done_cnt = 0;
  bit           in_flight = 0, m_last = 1, owner = 0, acc = 0;
  int           acc_idx = 0;
  logic [127:0] m_msg = '0, m_key = '0, m_rsp = '0, m_result = '0;
  logic         m_dec = 1'b0;
  logic [0:1]   reload = '0;
  int           grants[$];

  task automatic rand_job(input int i);
    req_valid[i]   = 1'b1;
    req_message[i] = {$urandom, $urandom, $urandom, $urandom};
    req_key[i]     = {$urandom, $urandom, $urandom, $urandom};
    req_decrypt[i] = 1'($urandom);
  endtask

  task automatic load_job(input int i, input logic [127:0] m, input logic [127:0] k, input logic d);
    req_valid[i] = 1'b1; req_message[i] = m; req_key[i] = k; req_decrypt[i] = d;
  endtask

  task automatic check_core_regs();
    chk("core_message", core_message, m_msg);
    chk("core_key", core_key, m_key);
    chk("core_selCypher", core_selCypher, m_dec);
    chk("rsp_data", rsp_data, m_rsp);
  endtask

  task automatic step();
    logic [0:1] g;
    int age, idx;
    @(negedge clk);
    acc = 0;
    if (reset) begin
      chk("reset_req_ready", req_ready, 0);
      in_flight = 0; m_last = 1; m_msg = '0; m_key = '0; m_dec = 1'b0; m_rsp = '0;
    end else if (!in_flight) begin
      g = '0;
      if (req_valid[0] && req_valid[1]) idx = m_last ? 0 : 1;
      else if (req_valid[0]) idx = 0;
      else idx = 1;
      if (req_valid != '0) g[idx] = 1'b1;
      chk("req_ready", req_ready, g);
      chk("rsp_valid_idle", rsp_valid, 0);
      chk("busy_idle", busy, 0);
      chk("core_start_idle", core_start, 0);
      check_core_regs();
      if (g != '0) begin
        in_flight = 1; t_acc = cyc; owner = idx[0];
        m_msg = req_message[idx]; m_key = req_key[idx]; m_dec = req_decrypt[idx];
        m_result = core_fn(m_msg, m_key, m_dec);
        grants.push_back(idx);
        acc = 1; acc_idx = idx;
      end
    end else begin
      age = cyc - t_acc;
      if (age == L + 2) m_rsp = m_result;
      g = '0;
      if (age >= L + 2) g[owner] = 1'b1;
      chk("rsp_valid", rsp_valid, g);
      chk("req_ready_busy", req_ready, 0);
      chk("busy", busy, 1);
      chk("core_start", core_start, age == 1);
      check_core_regs();
      if (age >= L + 2 && rsp_ready[owner]) begin
        in_flight = 0; m_last = owner; done_cnt++;
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (acc) begin
      req_valid[acc_idx] = 1'b0;
      if (reload[acc_idx]) rand_job(acc_idx);
    end
  endtask

  task automatic run_jobs(input int n, input int budget);
    int target, k;
    target = done_cnt + n;
    k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    chk("job_timeout", done_cnt >= target, 1);
  endtask

  task automatic run_to_age(input int a, input int budget);
    int k;
    k = 0;
    while (!(in_flight && cyc - t_acc >= a) && k < budget) begin
      step();
      k++;
    end
    chk("age_timeout", in_flight && cyc - t_acc >= a, 1);
  endtask

  initial begin
    int s0, base;
    reset = 1'b1; req_valid = '0; req_decrypt = '0; req_message = '0; req_key = '0; rsp_ready = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_core_message", core_message, 0);

    // Single encrypt on requester 0
    rsp_ready = 2'b11; s0 = starts;
    load_job(0, PT, KEY, 1'b0);
    run_jobs(1, 40);
    chk("fips_encrypt", rsp_data, CT);
    chk("one_core_start", starts - s0, 1);

    // Decrypt on requester 1
    load_job(1, CT, KEY, 1'b1);
    run_jobs(1, 40);
    chk("fips_decrypt", rsp_data, PT);

    // Backpressure with non-owner rsp_ready noise
    rsp_ready = 2'b00;
    rand_job(0);
    run_to_age(L + 2, 40);
    for (int k = 0; k < 20; k++) begin
      rsp_ready = (k == 8 || k == 9) ? 2'b01 : 2'b00;
      step();
    end
    rsp_ready = 2'b10;
    step();
    step();
    chk("bp_done", done_cnt, 3);

    // Reset during WAIT abandons the job
    rsp_ready = 2'b11;
    rand_job(1);
    run_to_age(5, 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_done", done_cnt, 3);

    // Tie after reset: 0,1,0,1
    base = grants.size();
    reload = 2'b11;
    rand_job(0); rand_job(1);
    run_jobs(4, 80);
    reload = 2'b00; req_valid = '0;
    for (int k = 0; k < 4; k++) chk($sformatf("tie_grant%0d", k), grants[base + k], k % 2);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) if (!req_valid[i] && $urandom_range(2) == 0) rand_job(i);
      rsp_ready = 2'($urandom);
      step();
    end
    req_valid = '0; rsp_ready = 2'b11;
    for (int c = 0; c < 40 && in_flight; c++) step();
    chk("drain_idle", in_flight, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
# aes_job_scheduler

Two-requester job scheduler that shares one AES128 core between independent clients. It accepts 128-bit message/key/direction jobs over valid/ready handshakes, arbitrates round-robin, and drives the core's `start`, `selCypher`, `message_in` and `key` inputs. It times the core's fixed latency, captures `message_out`, and returns the result to the owning requester. It sits between the bus-side interface logic and the AES128 core, alongside the AES128 instance at chip top level.

## Interface
Parameters:
- CORE_LATENCY, 11: cycles from the core_start cycle until core_result is valid; must be ≥ 1.
- CNT_W, 5: width of the latency counter; must hold CORE_LATENCY.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  [0:1]  per-requester job valid
- req_ready  out  [0:1]  per-requester job accept, one-hot or zero
- req_decrypt  in  [0:1]  1 = decrypt, 0 = encrypt
- req_message  in  [0:1][0:127]  per-requester data block
- req_key  in  [0:1][0:127]  per-requester key
- rsp_valid  out  [0:1]  result valid to the owning requester, one-hot or zero
- rsp_ready  in  [0:1]  requester accepts result
- rsp_data  out  [0:127]  result block, shared by both requesters
- core_start  out  1  one-cycle start pulse to the core
- core_selCypher  out  1  core direction (mirrors the latched req_decrypt)
- core_message  out  [0:127]  to core message_in
- core_key  out  [0:127]  to core key
- core_result  in  [0:127]  from core message_out
- busy  out  1  high in any state other than IDLE

## Operation
- FSM has four states: IDLE, LAUNCH, WAIT, RESPOND.
- IDLE:
  - If any req_valid is high, pick grant g: if only one requester is valid, it wins; if both are valid, g = !last_grant.
  - Assert req_ready[g] combinationally in this cycle. The handshake completes this cycle.
  - Latch req_message[g], req_key[g] and req_decrypt[g] into the core_* registers, latch g as owner, then go to LAUNCH.
- LAUNCH: core_start = 1 for exactly this cycle. Load the counter with CORE_LATENCY, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter equals 1, register core_result into rsp_data and go to RESPOND.
- RESPOND:
  - rsp_valid[owner] = 1.
  - On rsp_ready[owner], set last_grant to owner and go to IDLE.
  - rsp_ready of the non-owner is ignored.
- core_message, core_key and core_selCypher hold stable from LAUNCH until the next IDLE accept.
- req_ready is never asserted outside IDLE. Requesters must hold req_valid and their job data until accepted.
- Reset behaviour:
  - Reset forces IDLE, clears the counter, sets last_grant = 1 (requester 0 wins the first tie) and sets owner = 0.
  - Reset clears rsp_data and all core_* registers.
  - Reset mid-job abandons the job without producing a response. The core shares the same reset.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_data = 0, core_start = 0, core_selCypher = 0, core_message = 0, core_key = 0, busy = 0.
- Job accepted in cycle T:
  - core_start is high in T+1.
  - core_result is sampled at the end of cycle T+1+CORE_LATENCY.
  - rsp_valid rises in cycle T+2+CORE_LATENCY.
- Minimum job-to-job spacing is CORE_LATENCY+3 cycles. This applies when rsp_ready is already high and the next req_valid is waiting: the next accept happens in the cycle after the response handshake.
- Simultaneous req_valid with rsp_ready in the same cycle: the new job is accepted only in the following IDLE cycle. There is no overlap.
- rsp_valid stays high indefinitely until rsp_ready. Backpressure stalls the scheduler.

## Structure
- Package aes_sched_pkg holds:
  - state enum {IDLE, LAUNCH, WAIT, RESPOND}
  - AES_BLOCK_W = 128
  - NUM_REQ = 2
  - the 128-bit block typedef
- Sub-module aes_rr_arb2 holds the combinational 2-way round-robin grant. Inputs: req_valid and last_grant. Outputs: the one-hot grant and the grant index.
- Everything else lives in aes_job_scheduler: FSM, counter, latches.

## Test plan
- Single job: requester 0 submits an encrypt job with key 000102030405060708090a0b0c0d0e0f and message 00112233445566778899aabbccddeeff, and rsp_ready is held high. Required: rsp_valid[0] high in cycle T+2+CORE_LATENCY, rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, and exactly one core_start pulse.
- Decrypt on requester 1: 69c4e0d86a7b0430d8cdb78070b4c55a with the same key. Required: core_selCypher = 1 throughout the job, rsp_data = 00112233445566778899aabbccddeeff, and rsp_valid[1] only.
- Tie after reset: both requesters valid. Required grant order is 0, 1, 0, 1 over four jobs, and req_ready is never two-hot.
- Backpressure: rsp_ready[owner] held low for 20 cycles. Required: rsp_valid and rsp_data stay stable and req_ready stays 0; the scheduler returns to IDLE one cycle after rsp_ready rises.
- Reset mid-operation: assert reset during WAIT. Required: the next cycle is IDLE with all outputs at reset values, no rsp_valid for the aborted job, and requester 0 wins the next tie.
- Non-owner noise: pulse rsp_ready of the non-owner during RESPOND. Required: no state change.
